// File: rtl/audio_capture_pkg.sv
// Shared types and saturation limits for the audio capture engine and its
// shift/clamp helper.
package audio_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // Largest and smallest two's-complement values representable in w bits.
    function automatic int OUT_MAX(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int OUT_MIN(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift followed by a clamp to a narrower
// signed width.
module sat_shift
    import audio_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned OUT_W    = 10,
    parameter int unsigned SHIFT_W  = 3
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [SHIFT_W-1:0]  shift,
    output logic signed [OUT_W-1:0]    sat_c
);

    localparam logic signed [SAMPLE_W-1:0] MAX_S = SAMPLE_W'(OUT_MAX(OUT_W));
    localparam logic signed [SAMPLE_W-1:0] MIN_S = SAMPLE_W'(OUT_MIN(OUT_W));

    logic signed [SAMPLE_W-1:0] shifted;

    assign shifted = sample >>> shift;

    always_comb begin
        if (shifted > MAX_S) begin
            sat_c = MAX_S[OUT_W-1:0];
        end else if (shifted < MIN_S) begin
            sat_c = MIN_S[OUT_W-1:0];
        end else begin
            sat_c = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/audio_capture.sv
// Capture engine: decimates, rescales and stores a block of PCM samples into
// the sample RAM, with optional threshold trigger and abort.
module audio_capture
    import audio_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned OUT_W    = 10,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned DECIM_W  = 8,
    parameter int unsigned SHIFT_W  = 3
) (
    input  logic                       clk_100,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       req,
    input  logic                       abort,
    input  logic                       trig_en,
    input  logic        [SAMPLE_W-2:0] trig_thresh,
    input  logic        [DECIM_W-1:0]  decim,
    input  logic        [SHIFT_W-1:0]  shift,
    output logic                       write_enable,
    output logic        [ADDR_W-1:0]   addr,
    output logic        [OUT_W-1:0]    data_out,
    output logic                       busy,
    output logic                       done,
    output logic        [ADDR_W:0]     count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    cap_state_t state_q, state_d;

    logic [DECIM_W-1:0]  decim_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic [SAMPLE_W-2:0] thresh_q;
    logic [DECIM_W-1:0]  dcnt_q;

    logic                       accept_c;
    logic                       store_c;
    logic [DECIM_W-1:0]         dcnt_inc_c;
    logic [SAMPLE_W-1:0]        raw_u;
    logic [SAMPLE_W-1:0]        neg_c;
    logic [SAMPLE_W-2:0]        mag_c;
    logic signed [OUT_W-1:0]    sat_c;

    sat_shift #(
        .SAMPLE_W(SAMPLE_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_sat_shift (
        .sample(sample_in),
        .shift (shift_q),
        .sat_c (sat_c)
    );

    // Magnitude for the trigger; only the most-negative input has a negation
    // whose MSB is still set, and it saturates to all ones.
    assign raw_u = sample_in;
    assign neg_c = ~raw_u + SAMPLE_W'(1);

    always_comb begin
        if (!raw_u[SAMPLE_W-1]) begin
            mag_c = raw_u[SAMPLE_W-2:0];
        end else if (neg_c[SAMPLE_W-1]) begin
            mag_c = '1;
        end else begin
            mag_c = neg_c[SAMPLE_W-2:0];
        end
    end

    assign dcnt_inc_c = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus store/accept decisions; abort blocks any store.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        store_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !abort) begin
                    accept_c = 1'b1;
                    state_d  = trig_en ? ARM : CAPTURE;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid && (mag_c >= thresh_q)) begin
                    store_c = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample_valid && (dcnt_q == '0)) begin
                    store_c = 1'b1;
                    if (count == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            write_enable <= 1'b0;
            addr         <= '0;
            data_out     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count        <= '0;
            decim_q      <= '0;
            shift_q      <= '0;
            thresh_q     <= '0;
            dcnt_q       <= '0;
        end else begin
            write_enable <= store_c;
            busy         <= (state_d != IDLE);
            done         <= (state_q == DONE);
            if (accept_c) begin
                decim_q  <= decim;
                shift_q  <= shift;
                thresh_q <= trig_thresh;
                dcnt_q   <= '0;
                count    <= '0;
            end
            if (store_c) begin
                addr     <= count[ADDR_W-1:0];
                data_out <= sat_c;
                count    <= count + CNT_W'(1);
            end
            // A trigger store counts as strobe zero of the decimation cycle.
            if (store_c || (state_q == CAPTURE && sample_valid && !abort)) begin
                dcnt_q <= dcnt_inc_c;
            end
        end
    end

endmodule

// File: tb/tb_audio_capture.sv
// Scoreboard bench for audio_capture with DEPTH=8.
module tb_audio_capture;

    localparam int SAMPLE_W = 16;
    localparam int OUT_W    = 10;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int DECIM_W  = 8;
    localparam int SHIFT_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [OUT_W-1:0]  d;
    } wr_t;

    logic                       clk_100 = 1'b0;
    logic                       rst = 1'b1;
    logic                       sample_valid = 1'b0;
    logic signed [SAMPLE_W-1:0] sample_in = '0;
    logic                       req = 1'b0;
    logic                       abort = 1'b0;
    logic                       trig_en = 1'b0;
    logic        [SAMPLE_W-2:0] trig_thresh = '0;
    logic        [DECIM_W-1:0]  decim = '0;
    logic        [SHIFT_W-1:0]  shift = '0;
    logic                       write_enable;
    logic        [ADDR_W-1:0]   addr;
    logic        [OUT_W-1:0]    data_out;
    logic                       busy;
    logic                       done;
    logic        [ADDR_W:0]     count;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  obs_rd = 0;
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_we_cyc = 0;
    int  last_done_cyc = 0;
    int  done_cnt = 0;

    audio_capture #(
        .SAMPLE_W(SAMPLE_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DECIM_W (DECIM_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk_100     (clk_100),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .req         (req),
        .abort       (abort),
        .trig_en     (trig_en),
        .trig_thresh (trig_thresh),
        .decim       (decim),
        .shift       (shift),
        .write_enable(write_enable),
        .addr        (addr),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk_100 = ~clk_100;

    // Record every RAM write and done pulse, sampled mid-cycle.
    always @(negedge clk_100) begin
        cyc = cyc + 1;
        if (write_enable === 1'b1) begin
            obs_q.push_back('{a: addr, d: data_out});
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
        end
    end

    function automatic logic [OUT_W-1:0] exp_sat(input int v, input int sh);
        int r;
        r = v >>> sh;
        if (r > 511) r = 511;
        else if (r < -512) r = -512;
        return OUT_W'(r);
    endfunction

    task automatic drive(input logic v, input logic signed [SAMPLE_W-1:0] s);
        sample_valid = v;
        sample_in    = s;
        @(posedge clk_100);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        tests++; if (write_enable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", write_enable); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (addr !== '0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_out); end
        tests++; if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_plain();
        wr_t e;
        int  dbase;
        dbase = done_cnt;
        decim = 0; shift = 0; trig_en = 0;
        req = 1'b1;
        idle(1);
        req = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL plain_busy_rise: got %b expected 1", busy); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{a: ADDR_W'(i), d: exp_sat(i, 0)});
            drive(1'b1, SAMPLE_W'(i));
        end
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("FAIL plain_write: none, expected addr %0d data %h", e.a, e.d);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    fails++; $display("FAIL plain_write: got addr %0d data %h, expected addr %0d data %h", obs_q[obs_rd].a, obs_q[obs_rd].d, e.a, e.d);
                end
                obs_rd++;
            end
        end
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL plain_extra: got %0d extra writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL plain_count: got %0d expected 8", count); end
        tests++; if (done_cnt != dbase + 1) begin fails++; $display("FAIL plain_done_cnt: got %0d expected %0d", done_cnt - dbase, 1); end
        tests++; if (last_done_cyc != last_we_cyc + 1) begin fails++; $display("FAIL plain_done_timing: got cycle %0d expected %0d", last_done_cyc, last_we_cyc + 1); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL plain_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_decim_sat();
        wr_t e;
        int  n;
        int  v;
        int  dbase;
        dbase = done_cnt;
        n = 0;
        decim = 2; shift = 3; trig_en = 0;
        req = 1'b1;
        idle(1);
        req = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k < 13) v = (k % 2 == 1) ? 32767 : -32768;
            else v = k * 37 - 600;
            if ((k - 1) % 3 == 0) begin
                exp_q.push_back('{a: ADDR_W'(n), d: exp_sat(v, 3)});
                n++;
            end
            drive(1'b1, SAMPLE_W'(v));
            idle(3);
        end
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("FAIL decim_write: none, expected addr %0d data %h", e.a, e.d);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    fails++; $display("FAIL decim_write: got addr %0d data %h, expected addr %0d data %h", obs_q[obs_rd].a, obs_q[obs_rd].d, e.a, e.d);
                end
                obs_rd++;
            end
        end
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL decim_extra: got %0d extra writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        tests++; if (done_cnt != dbase + 1) begin fails++; $display("FAIL decim_done_cnt: got %0d expected 1", done_cnt - dbase); end
    endtask

    task automatic test_trigger();
        wr_t e;
        int  v;
        int  n;
        decim = 1; shift = 0; trig_en = 1; trig_thresh = 15'd1000;
        req = 1'b1;
        idle(1);
        req = 1'b0;
        drive(1'b1, 16'sd10);
        drive(1'b1, -16'sd500);
        idle(1);
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL trig_early_write: got %0d writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL trig_arm_busy: got %b expected 1", busy); end
        tests++; if (count !== '0) begin fails++; $display("FAIL trig_arm_count: got %0d expected 0", count); end
        exp_q.push_back('{a: 3'd0, d: exp_sat(-1200, 0)});
        drive(1'b1, -16'sd1200);
        n = 1;
        for (int j = 1; j <= 14; j++) begin
            v = (j == 1) ? 5 : j * 70 - 500;
            if (j % 2 == 0) begin
                exp_q.push_back('{a: ADDR_W'(n), d: exp_sat(v, 0)});
                n++;
            end
            drive(1'b1, SAMPLE_W'(v));
            idle(1);
        end
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("FAIL trig_write: none, expected addr %0d data %h", e.a, e.d);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    fails++; $display("FAIL trig_write: got addr %0d data %h, expected addr %0d data %h", obs_q[obs_rd].a, obs_q[obs_rd].d, e.a, e.d);
                end
                obs_rd++;
            end
        end
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL trig_extra: got %0d extra writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_trig_min();
        int dbase;
        dbase = done_cnt;
        decim = 0; shift = 0; trig_en = 1; trig_thresh = 15'h7FFF;
        req = 1'b1;
        idle(1);
        req = 1'b0;
        drive(1'b1, 16'sh7FFE);
        drive(1'b1, 16'sh8000);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(2);
        tests++;
        if (obs_q.size() != obs_rd + 1) begin
            fails++; $display("FAIL trigmin_writes: got %0d expected 1", obs_q.size() - obs_rd);
        end else if (obs_q[obs_rd] !== '{a: 3'd0, d: 10'h200}) begin
            fails++; $display("FAIL trigmin_write: got addr %0d data %h expected addr 0 data 200", obs_q[obs_rd].a, obs_q[obs_rd].d);
        end
        obs_rd = obs_q.size();
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL trigmin_count: got %0d expected 1", count); end
        tests++; if (done_cnt != dbase) begin fails++; $display("FAIL trigmin_done: got %0d pulses expected 0", done_cnt - dbase); end
    endtask

    task automatic test_abort();
        wr_t e;
        int  dbase;
        dbase = done_cnt;
        decim = 0; shift = 1; trig_en = 0;
        req = 1'b1;
        idle(1);
        req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back('{a: ADDR_W'(i - 1), d: exp_sat(i * 100, 1)});
            drive(1'b1, SAMPLE_W'(i * 100));
        end
        abort = 1'b1;
        drive(1'b1, 16'sd400);
        abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        drive(1'b1, 16'sd500);
        idle(2);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL abort_count: got %0d expected 3", count); end
        req = 1'b1;
        idle(1);
        req = 1'b0;
        exp_q.push_back('{a: 3'd0, d: exp_sat(64, 1)});
        drive(1'b1, 16'sd64);
        idle(1);
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL abort_restart_count: got %0d expected 1", count); end
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("FAIL abort_write: none, expected addr %0d data %h", e.a, e.d);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    fails++; $display("FAIL abort_write: got addr %0d data %h, expected addr %0d data %h", obs_q[obs_rd].a, obs_q[obs_rd].d, e.a, e.d);
                end
                obs_rd++;
            end
        end
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL abort_extra: got %0d extra writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        tests++; if (done_cnt != dbase) begin fails++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - dbase); end
    endtask

    task automatic test_collisions();
        wr_t e;
        decim = 0; shift = 0; trig_en = 0;
        req = 1'b1; abort = 1'b1;
        idle(1);
        req = 1'b0; abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coll_req_abort_busy: got %b expected 0", busy); end
        drive(1'b1, 16'sd5);
        req = 1'b1;
        idle(1);
        req = 1'b0;
        exp_q.push_back('{a: 3'd0, d: 10'd11});
        drive(1'b1, 16'sd11);
        exp_q.push_back('{a: 3'd1, d: 10'd22});
        drive(1'b1, 16'sd22);
        req = 1'b1;
        exp_q.push_back('{a: 3'd2, d: 10'd33});
        drive(1'b1, 16'sd33);
        req = 1'b0;
        decim = 3; shift = 2;
        exp_q.push_back('{a: 3'd3, d: 10'd44});
        drive(1'b1, 16'sd44);
        rst = 1'b1;
        drive(1'b1, 16'sd55);
        tests++; if (write_enable !== 1'b0) begin fails++; $display("FAIL coll_rst_we: got %b expected 0", write_enable); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coll_rst_busy: got %b expected 0", busy); end
        tests++; if (addr !== '0) begin fails++; $display("FAIL coll_rst_addr: got %0d expected 0", addr); end
        tests++; if (data_out !== '0) begin fails++; $display("FAIL coll_rst_data: got %h expected 0", data_out); end
        tests++; if (count !== '0) begin fails++; $display("FAIL coll_rst_count: got %0d expected 0", count); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL coll_rst_done: got %b expected 0", done); end
        rst = 1'b0;
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("FAIL coll_write: none, expected addr %0d data %h", e.a, e.d);
            end else begin
                if (obs_q[obs_rd] !== e) begin
                    fails++; $display("FAIL coll_write: got addr %0d data %h, expected addr %0d data %h", obs_q[obs_rd].a, obs_q[obs_rd].d, e.a, e.d);
                end
                obs_rd++;
            end
        end
        tests++; if (obs_q.size() != obs_rd) begin fails++; $display("FAIL coll_extra: got %0d extra writes expected 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_decim_sat();
        test_trigger();
        test_trig_min();
        test_abort();
        test_collisions();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_capture.md
# audio_capture

Parametrised capture engine that stores a decimated, rescaled block of PCM microphone samples into a dual-port sample RAM for the tuner's pitch-analysis stage. It sits between the PDM decimator's `valid`/`data` stream and the sample RAM write port. It extends the original fixed 1024×10-bit, clock-paced capture with the following features:
- sample-count decimation
- runtime gain shift with saturation
- optional amplitude-threshold trigger
- abort
- a captured-sample count

## Interface
Parameters:
- `SAMPLE_W`, 16: signed input sample width
- `OUT_W`, 10: signed stored sample width, ≤ `SAMPLE_W`
- `DEPTH`, 1024: samples per capture, power of two, ≥ 2
- `ADDR_W`, `$clog2(DEPTH)`: RAM address width
- `DECIM_W`, 8: decimation control width
- `SHIFT_W`, 3: gain shift control width

Ports:
- `clk_100`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `sample_valid`, in, 1: one-cycle strobe, new decimator sample.
- `sample_in`, in, `SAMPLE_W`: signed sample, valid with the strobe.
- `req`, in, 1: start capture. Sampled only in IDLE.
- `abort`, in, 1: cancel capture, return to IDLE, no `done`.
- `trig_en`, in, 1: 1 = wait for threshold before storing.
- `trig_thresh`, in, `SAMPLE_W-1`: unsigned magnitude threshold.
- `decim`, in, `DECIM_W`: store every (`decim`+1)-th valid sample.
- `shift`, in, `SHIFT_W`: arithmetic right shift applied before saturation.
- `write_enable`, out, 1: RAM write strobe.
- `addr`, out, `ADDR_W`: RAM write address.
- `data_out`, out, `OUT_W`: RAM write data.
- `busy`, out, 1: high in ARM and CAPTURE.
- `done`, out, 1: one-cycle pulse, capture complete.
- `count`, out, `ADDR_W+1`: samples stored in the current or last capture.

## Operation
- States: IDLE, ARM, CAPTURE, DONE.
- **IDLE**
  - On `req`: latch `decim`, `shift`, `trig_en`, `trig_thresh`, and clear `count` and the decimation counter.
  - Go to ARM if `trig_en`=1, otherwise go to CAPTURE.
- **ARM**
  - On `sample_valid` with |`sample_in`| ≥ `trig_thresh`: store that sample at address 0 and go to CAPTURE.
  - Magnitude of the most-negative input saturates to the maximum positive value.
  - Samples below threshold are discarded.
- **CAPTURE**
  - The decimation counter counts valid strobes.
  - The first valid strobe after entry stores a sample, unless ARM already stored the trigger sample. In that case the next store occurs `decim`+1 strobes after the trigger.
  - After that, one sample is stored every `decim`+1 strobes.
  - After the DEPTH-th store, go to DONE.
- **DONE**: pulse `done` for one cycle, then go to IDLE.
- **Store**
  - `data_out` = saturate_OUT_W(`sample_in` >>> `shift`). The shift is arithmetic.
  - The result clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - `addr` = `count` before increment. Addresses run 0..DEPTH−1 and never wrap within a capture.
- **`abort`**
  - `abort` in ARM or CAPTURE goes to IDLE on the next edge.
  - No further writes occur. The pending `write_enable` from the same-cycle store is suppressed.
  - `count` holds the number of samples already written. `done` stays low.
- `req` while `busy` is ignored.
- `abort` and `req` in the same cycle: `abort` wins.
- `rst` overrides everything.

## Timing
- Reset values:
  - state IDLE
  - `write_enable`, `busy`, `done` = 0
  - `addr`, `data_out`, `count` = 0
- Store latency: `sample_valid` at edge t produces `write_enable`=1 with `addr`/`data_out` at t+1, for exactly one cycle.
- `count` increments at the same edge that raises `write_enable`.
- `busy` rises the cycle after `req` is sampled.
- `done` pulses one cycle after the final `write_enable`. `busy` falls with `done`.
- Back-to-back `sample_valid` on consecutive cycles is supported. There is no back-pressure and no stored sample is lost.
- `decim`=0 means every sample is stored.
- Parameter changes mid-capture have no effect because they are latched at `req`.

## Structure
- `audio_capture_pkg`: state enum `cap_state_t` and the saturation helper constants (`OUT_MAX`, `OUT_MIN` as functions of `OUT_W`).
- Sub-module `sat_shift`: combinational arithmetic shift plus clamp, parametrised on `SAMPLE_W`, `OUT_W`, `SHIFT_W`. It is reused by the spectrum front end.
- The FSM, decimation counter, and address/count registers live in `audio_capture`.

## Test plan
- **Plain capture:** DEPTH=8, `decim`=0, `shift`=0, ramp inputs 0..7 on back-to-back strobes.
  - Writes addr 0..7 with data 0..7.
  - `done` one cycle after the last write; `count`=8.
- **Decimation and saturation:** `decim`=2, `shift`=3, inputs 16'sh7FFF every 4th cycle.
  - Stores strobes 1, 4, 7, …
  - `data_out`=10'h1FF (clamped); negative 16'sh8000 gives 10'h200.
- **Trigger:** `trig_en`=1, `trig_thresh`=1000, inputs 10, −500, −1200, 5, ….
  - −1200 is stored at addr 0, then later samples per `decim`.
  - No write occurs before the trigger.
- **Abort mid-capture:** `abort` after 3 stores, in the same cycle as a `sample_valid`.
  - Exactly 3 writes; `count`=3; `done` never asserted.
  - Immediate new `req` restarts at addr 0.
- **Collisions:** `req`+`abort` in the same cycle stays in IDLE; `req` during CAPTURE is ignored; `rst` mid-capture returns all outputs to reset values at the next edge.
